// File: rtl/mem_stage_pkg.sv
// Shared pipeline package: instruction-type tags, data-memory sizing and
// the EX/MEM pipeline-register payload.
package mem_stage_pkg;

   // Data-memory word-address width (DEPTH = 2**DMEM_ADDR_W words).
   localparam int DMEM_ADDR_W = 6;

   // Instruction-type tags carried down the pipeline for tracking.
   localparam logic [3:0] BUBBLE     = 4'd0;
   localparam logic [3:0] INS_RTYPE  = 4'd1;
   localparam logic [3:0] INS_ITYPE  = 4'd2;
   localparam logic [3:0] INS_LOAD   = 4'd3;
   localparam logic [3:0] INS_STORE  = 4'd4;
   localparam logic [3:0] INS_BRANCH = 4'd5;
   localparam logic [3:0] INS_JUMP   = 4'd6;

   // Everything EX hands to MEM in one bundle.
   typedef struct packed {
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic        branch;
      logic        zero;
      logic [31:0] alu_r;
      logic [31:0] in_b;
      logic [31:0] pc;
      logic [4:0]  dest_r;
      logic [3:0]  ins_type;
      logic [3:0]  ins_number;
   } ex_mem_t;

   localparam int EX_MEM_W = $bits(ex_mem_t);

   // A bubble is an all-zero bundle tagged as BUBBLE.
   localparam ex_mem_t EX_MEM_BUBBLE = '{ins_type: BUBBLE, default: '0};

endpackage

// File: rtl/mem_stage_reg_exe_mem.sv
// EX/MEM pipeline register. Same rst/flush/stall behaviour as the other
// pipeline registers: rst > flush > stall > load.
module Reg_EXE_MEM
   import mem_stage_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_stall,
   input  logic                i_flush,
   input  logic [EX_MEM_W-1:0] i_d,
   output logic [EX_MEM_W-1:0] o_q
);

   logic [EX_MEM_W-1:0] r_q;

   // Load a bubble on rst/flush, hold on stall, otherwise capture EX.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (rst || i_flush) begin
         r_q <= EX_MEM_BUBBLE;
      end else if (!i_stall) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, word-addressed local data memory,
// branch resolution and forwarding of write-back control to WB.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        ex_wreg,
   input  logic        ex_m2reg,
   input  logic        ex_wmem,
   input  logic [31:0] ex_aluR,
   input  logic [31:0] ex_inB,
   input  logic [4:0]  ex_destR,
   input  logic        ex_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_zero,
   input  logic [3:0]  EXE_ins_type,
   input  logic [3:0]  EXE_ins_number,
   output logic        mem_wreg,
   output logic        mem_m2reg,
   output logic [31:0] mem_aluR,
   output logic [31:0] mem_mdata,
   output logic [4:0]  mem_destR,
   output logic        mem_pcsrc,
   output logic [31:0] mem_branch_pc,
   output logic [3:0]  MEM_ins_type,
   output logic [3:0]  MEM_ins_number
);

   localparam int DEPTH = 1 << ADDR_W;

   ex_mem_t           w_ex;
   ex_mem_t           w_mem;
   logic [ADDR_W-1:0] w_idx;
   logic [31:0]       r_dmem [DEPTH];

   assign w_ex = '{
      wreg:       ex_wreg,
      m2reg:      ex_m2reg,
      wmem:       ex_wmem,
      branch:     ex_branch,
      zero:       ex_zero,
      alu_r:      ex_aluR,
      in_b:       ex_inB,
      pc:         ex_pc,
      dest_r:     ex_destR,
      ins_type:   EXE_ins_type,
      ins_number: EXE_ins_number
   };

   Reg_EXE_MEM u_reg_exe_mem (
      .clk     (clk),
      .rst     (rst),
      .i_stall (stall),
      .i_flush (flush),
      .i_d     (w_ex),
      .o_q     (w_mem)
   );

   // Byte offset and bits above the memory size are dropped: addresses
   // wrap modulo DEPTH words and misalignment is silently ignored.
   assign w_idx = w_mem.alu_r[ADDR_W+1:2];

   // Commit the store sitting in MEM, unless reset lands on this edge.
   // A stalled store rewrites the same word with the same data.
   always_ff @(posedge clk) begin
      // NOTE: the memory array is deliberately not reset; only its write is gated.
      if (!rst && w_mem.wmem) begin
         r_dmem[w_idx] <= w_mem.in_b;
      end
   end

   // Asynchronous read: a same-cycle store to this word is seen next cycle.
   assign mem_mdata      = r_dmem[w_idx];

   assign mem_wreg       = w_mem.wreg;
   assign mem_m2reg      = w_mem.m2reg;
   assign mem_aluR       = w_mem.alu_r;
   assign mem_destR      = w_mem.dest_r;
   assign mem_pcsrc      = w_mem.branch & w_mem.zero;
   assign mem_branch_pc  = w_mem.pc;
   assign MEM_ins_type   = w_mem.ins_type;
   assign MEM_ins_number = w_mem.ins_number;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: reset, store/load, wrap-around,
// branch resolution, stall/flush and reset-suppressed stores.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        ex_wreg;
   logic        ex_m2reg;
   logic        ex_wmem;
   logic [31:0] ex_aluR;
   logic [31:0] ex_inB;
   logic [4:0]  ex_destR;
   logic        ex_branch;
   logic [31:0] ex_pc;
   logic        ex_zero;
   logic [3:0]  EXE_ins_type;
   logic [3:0]  EXE_ins_number;
   logic        mem_wreg;
   logic        mem_m2reg;
   logic [31:0] mem_aluR;
   logic [31:0] mem_mdata;
   logic [4:0]  mem_destR;
   logic        mem_pcsrc;
   logic [31:0] mem_branch_pc;
   logic [3:0]  MEM_ins_type;
   logic [3:0]  MEM_ins_number;

   int n_vec = 0;
   int n_err = 0;

   mem_stage #(.ADDR_W(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .ex_wreg        (ex_wreg),
      .ex_m2reg       (ex_m2reg),
      .ex_wmem        (ex_wmem),
      .ex_aluR        (ex_aluR),
      .ex_inB         (ex_inB),
      .ex_destR       (ex_destR),
      .ex_branch      (ex_branch),
      .ex_pc          (ex_pc),
      .ex_zero        (ex_zero),
      .EXE_ins_type   (EXE_ins_type),
      .EXE_ins_number (EXE_ins_number),
      .mem_wreg       (mem_wreg),
      .mem_m2reg      (mem_m2reg),
      .mem_aluR       (mem_aluR),
      .mem_mdata      (mem_mdata),
      .mem_destR      (mem_destR),
      .mem_pcsrc      (mem_pcsrc),
      .mem_branch_pc  (mem_branch_pc),
      .MEM_ins_type   (MEM_ins_type),
      .MEM_ins_number (MEM_ins_number)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a neutral instruction with no side effects.
   task automatic idle();
      stall = 1'b0; flush = 1'b0;
      ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_wmem = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0;
      ex_aluR = '0; ex_inB = '0; ex_pc = '0; ex_destR = '0;
      EXE_ins_type = 4'd0; EXE_ins_number = 4'd0;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      idle();
      ex_wmem = 1'b1; ex_aluR = addr; ex_inB = data;
      EXE_ins_type = 4'd4; EXE_ins_number = 4'd1;
   endtask

   task automatic load(input logic [31:0] addr, input logic [4:0] dest);
      idle();
      ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_aluR = addr; ex_destR = dest;
      EXE_ins_type = 4'd3; EXE_ins_number = 4'd2;
   endtask

   function automatic logic [111:0] all_outs();
      return {mem_wreg, mem_m2reg, mem_aluR, mem_mdata, mem_destR, mem_pcsrc,
              mem_branch_pc, MEM_ins_type, MEM_ins_number};
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         rst = 1'b1; stall = 1'b0; flush = 1'b0;
         ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_wmem = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
         ex_aluR = $urandom; ex_inB = $urandom; ex_pc = $urandom | 32'h1;
         ex_destR = 5'($urandom_range(1, 31));
         EXE_ins_type = 4'($urandom_range(1, 15)); EXE_ins_number = 4'($urandom_range(1, 15));
         tick();
         n_vec++; if (all_outs() !== '0) begin n_err++; $display("FAIL reset_outs[%0d] got %h want 0", i, all_outs()); end
      end
      rst = 1'b0;
      idle();
   endtask

   task automatic test_store_load();
      store(32'h0000_0010, 32'hDEADBEEF);
      tick();
      load(32'h0000_0010, 5'd9);
      tick();
      n_vec++; if (mem_mdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL st_ld_mdata got %h want deadbeef", mem_mdata); end
      n_vec++; if (mem_destR !== 5'd9) begin n_err++; $display("FAIL st_ld_destR got %0d want 9", mem_destR); end
      n_vec++; if ({mem_wreg, mem_m2reg} !== 2'b11) begin n_err++; $display("FAIL st_ld_ctrl got %b want 11", {mem_wreg, mem_m2reg}); end
      // Overwrite the same word: while the store is in MEM the read shows old data.
      store(32'h0000_0010, 32'hCAFEF00D);
      tick();
      n_vec++; if (mem_mdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL same_cycle_old got %h want deadbeef", mem_mdata); end
      load(32'h0000_0010, 5'd3);
      tick();
      n_vec++; if (mem_mdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL st_ld_new got %h want cafef00d", mem_mdata); end
      idle();
   endtask

   task automatic test_wrap();
      store(32'h0000_0104, 32'h0000_1234);
      tick();
      load(32'h0000_0004, 5'd4);
      tick();
      n_vec++; if (mem_mdata !== 32'h0000_1234) begin n_err++; $display("FAIL wrap_ld got %h want 00001234", mem_mdata); end
      load(32'h0000_0007, 5'd4);
      tick();
      n_vec++; if (mem_mdata !== 32'h0000_1234) begin n_err++; $display("FAIL unaligned_ld got %h want 00001234", mem_mdata); end
      n_vec++; if (mem_aluR !== 32'h0000_0007) begin n_err++; $display("FAIL unaligned_aluR got %h want 00000007", mem_aluR); end
      idle();
   endtask

   task automatic test_branch();
      idle();
      ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 32'h40; EXE_ins_type = 4'd5;
      tick();
      n_vec++; if (mem_pcsrc !== 1'b1) begin n_err++; $display("FAIL br_taken got %b want 1", mem_pcsrc); end
      n_vec++; if (mem_branch_pc !== 32'h40) begin n_err++; $display("FAIL br_pc got %h want 00000040", mem_branch_pc); end
      ex_zero = 1'b0; ex_pc = 32'h80;
      tick();
      n_vec++; if (mem_pcsrc !== 1'b0) begin n_err++; $display("FAIL br_not_taken got %b want 0", mem_pcsrc); end
      n_vec++; if (mem_branch_pc !== 32'h80) begin n_err++; $display("FAIL br_pc2 got %h want 00000080", mem_branch_pc); end
      ex_branch = 1'b0; ex_zero = 1'b1;
      tick();
      n_vec++; if (mem_pcsrc !== 1'b0) begin n_err++; $display("FAIL nobr_zero got %b want 0", mem_pcsrc); end
      // A taken branch held by stall keeps pcsrc asserted until it leaves.
      ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 32'hC0;
      tick();
      stall = 1'b1; ex_branch = 1'b0; ex_zero = 1'b0; ex_pc = 32'h0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++; if ({mem_pcsrc, mem_branch_pc} !== {1'b1, 32'hC0}) begin n_err++; $display("FAIL br_stall[%0d] got %b/%h want 1/000000c0", i, mem_pcsrc, mem_branch_pc); end
      end
      stall = 1'b0;
      tick();
      n_vec++; if (mem_pcsrc !== 1'b0) begin n_err++; $display("FAIL br_leave got %b want 0", mem_pcsrc); end
      idle();
   endtask

   task automatic test_stall_flush();
      load(32'h0000_0010, 5'd7);
      EXE_ins_type = 4'd3; EXE_ins_number = 4'd7;
      tick();
      stall = 1'b1;
      ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_aluR = 32'h0000_0104; ex_destR = 5'd30;
      EXE_ins_type = 4'd9; EXE_ins_number = 4'd12;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if ({MEM_ins_type, MEM_ins_number} !== {4'd3, 4'd7}) begin n_err++; $display("FAIL stall_tags[%0d] got %h want 37", i, {MEM_ins_type, MEM_ins_number}); end
         n_vec++; if ({mem_wreg, mem_m2reg, mem_destR, mem_aluR, mem_mdata} !== {1'b1, 1'b1, 5'd7, 32'h10, 32'hCAFEF00D}) begin
            n_err++; $display("FAIL stall_hold[%0d] got %b%b %0d %h %h want 11 7 00000010 cafef00d", i, mem_wreg, mem_m2reg, mem_destR, mem_aluR, mem_mdata);
         end
      end
      flush = 1'b1;
      tick();
      n_vec++; if (all_outs() !== {2'b00, 32'h0, mem_mdata, 5'd0, 1'b0, 32'h0, 4'd0, 4'd0}) begin n_err++; $display("FAIL flush_stall_bubble got %h want bubble", all_outs()); end
      n_vec++; if ({mem_wreg, MEM_ins_type} !== 5'd0) begin n_err++; $display("FAIL flush_wreg_type got %b/%0d want 0/0", mem_wreg, MEM_ins_type); end
      // A store already in MEM still commits when a flush hits.
      store(32'h0000_0030, 32'h0000_0077);
      tick();
      flush = 1'b1;
      tick();
      // A store flushed while still in EX never reaches memory.
      store(32'h0000_0030, 32'h0000_0099);
      flush = 1'b1;
      tick();
      load(32'h0000_0030, 5'd1);
      tick();
      n_vec++; if (mem_mdata !== 32'h0000_0077) begin n_err++; $display("FAIL flush_store got %h want 00000077", mem_mdata); end
      idle();
   endtask

   task automatic test_reset_store();
      store(32'h0000_0020, 32'h1111_2222);
      tick();
      idle();
      tick();
      store(32'h0000_0020, 32'h3333_4444);
      tick();
      rst = 1'b1;
      idle();
      tick();
      n_vec++; if (all_outs() !== '0) begin n_err++; $display("FAIL mid_reset_outs got %h want 0", all_outs()); end
      rst = 1'b0;
      load(32'h0000_0020, 5'd2);
      tick();
      n_vec++; if (mem_mdata !== 32'h1111_2222) begin n_err++; $display("FAIL rst_store_suppress got %h want 11112222", mem_mdata); end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_store_load();
      test_wrap();
      test_branch();
      test_stall_flush();
      test_reset_store();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
